// File: rtl/prog_updown_counter.sv
// Programmable up/down counter: tick prescaler, mode FSM, run/stop/clear FSM, count datapath.
// Optional BTN_EDGE_DET_EN: registered rising-edge detect on every button input.
module prog_updown_counter #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TICK_HZ   = 10,
  parameter int MAX_COUNT = 9999,
  parameter int STEP_W    = 4,
  localparam int CNT_W    = $clog2(MAX_COUNT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_mode,
  input  logic              btn_run_stop,
  input  logic              btn_clear,
  input  logic              load,
  input  logic [CNT_W-1:0]  load_value,
  input  logic [STEP_W-1:0] step,
  input  logic              wrap_en,
  output logic [CNT_W-1:0]  count,
  output logic              tc_pulse,
  output logic              mode,
  output logic              running,
  output logic [1:0]        led_mode,
  output logic [1:0]        led_run_stop
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int XW  = ((CNT_W > STEP_W) ? CNT_W : STEP_W) + 1;

  localparam logic [PW-1:0]    P_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0]    P_ONE  = PW'(1);
  localparam logic [CNT_W-1:0] C_MAX  = CNT_W'(MAX_COUNT);
  localparam logic [XW-1:0]    X_MAX  = XW'(MAX_COUNT);
  localparam logic [XW-1:0]    X_MOD  = XW'(MAX_COUNT + 1);

  typedef enum logic {
    MODE_UP   = 1'b0,
    MODE_DOWN = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    RS_STOP  = 2'b00,
    RS_RUN   = 2'b01,
    RS_CLEAR = 2'b10
  } run_e;

  mode_e r_mode;
  mode_e w_mode_nxt;
  run_e  r_run;
  run_e  w_run_nxt;

  logic             w_btn_mode;
  logic             w_btn_rs;
  logic             w_btn_clr;

  logic [PW-1:0]    r_presc;
  logic             w_tick;

  logic [CNT_W-1:0] r_count;
  logic             r_tc;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_tc_nxt;
  logic             w_sat;

  logic [XW-1:0]    w_cnt_x;
  logic [XW-1:0]    w_step_x;
  logic [XW-1:0]    w_sum_x;
  logic [CNT_W-1:0] w_upd;
  logic             w_ovf;

`ifdef BTN_EDGE_DET_EN
  logic [2:0] r_btn_q;
  logic [2:0] r_btn_evt;

  // One-cycle event per rising edge of each button; a held button acts once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_btn_q   <= '0;
      r_btn_evt <= '0;
    end else begin
      r_btn_q   <= {btn_clear, btn_run_stop, btn_mode};
      r_btn_evt <= {btn_clear, btn_run_stop, btn_mode} & ~r_btn_q;
    end
  end

  assign w_btn_mode = r_btn_evt[0];
  assign w_btn_rs   = r_btn_evt[1];
  assign w_btn_clr  = r_btn_evt[2];
`else
  assign w_btn_mode = btn_mode;
  assign w_btn_rs   = btn_run_stop;
  assign w_btn_clr  = btn_clear;
`endif

  // Direction state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode <= MODE_UP;
    end else begin
      r_mode <= w_mode_nxt;
    end
  end

  // Direction toggles on each mode button event
  always_comb begin
    w_mode_nxt = r_mode;
    if (w_btn_mode) begin
      w_mode_nxt = (r_mode == MODE_UP) ? MODE_DOWN : MODE_UP;
    end
  end

  // Run/stop/clear state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_run <= RS_STOP;
    end else begin
      r_run <= w_run_nxt;
    end
  end

  // Run/stop/clear transitions; saturation and run_stop both request STOP
  always_comb begin
    w_run_nxt = r_run;
    unique case (r_run)
      RS_STOP: begin
        if (w_btn_rs) begin
          w_run_nxt = RS_RUN;
        end else if (w_btn_clr) begin
          w_run_nxt = RS_CLEAR;
        end
      end
      RS_RUN: begin
        if (w_btn_rs || w_sat) begin
          w_run_nxt = RS_STOP;
        end
      end
      RS_CLEAR: w_run_nxt = RS_STOP;
      default:  w_run_nxt = RS_STOP;
    endcase
  end

  assign w_tick = (r_run == RS_RUN) && (r_presc == P_LAST);

  // Prescaler advances only while running, keeps phase in STOP
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
    end else begin
      unique case (r_run)
        RS_RUN:   r_presc <= w_tick ? '0 : r_presc + P_ONE;
        RS_CLEAR: r_presc <= '0;
        default:  r_presc <= r_presc;
      endcase
    end
  end

  assign w_cnt_x  = XW'(r_count);
  assign w_step_x = XW'(step);
  assign w_sum_x  = w_cnt_x + w_step_x;

  // Candidate count for a tick, with boundary-crossing flag
  always_comb begin
    w_upd = r_count;
    w_ovf = 1'b0;
    if (r_mode == MODE_UP) begin
      if (w_sum_x <= X_MAX) begin
        w_upd = CNT_W'(w_sum_x);
      end else begin
        w_ovf = 1'b1;
        w_upd = wrap_en ? CNT_W'(w_sum_x - X_MOD) : C_MAX;
      end
    end else begin
      if (w_cnt_x >= w_step_x) begin
        w_upd = CNT_W'(w_cnt_x - w_step_x);
      end else begin
        w_ovf = 1'b1;
        w_upd = wrap_en ? CNT_W'(w_cnt_x + X_MOD - w_step_x) : '0;
      end
    end
  end

  // Count update priority: clear, then load, then tick
  always_comb begin
    w_cnt_nxt = r_count;
    w_tc_nxt  = 1'b0;
    w_sat     = 1'b0;
    if (r_run == RS_CLEAR) begin
      w_cnt_nxt = '0;
    end else if (load) begin
      w_cnt_nxt = (load_value > C_MAX) ? C_MAX : load_value;
    end else if (w_tick) begin
      w_cnt_nxt = w_upd;
      w_tc_nxt  = w_ovf;
      w_sat     = w_ovf & ~wrap_en;
    end
  end

  // Count and terminal-count pulse registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_tc    <= 1'b0;
    end else begin
      r_count <= w_cnt_nxt;
      r_tc    <= w_tc_nxt;
    end
  end

  assign count    = r_count;
  assign tc_pulse = r_tc;
  assign mode     = (r_mode == MODE_DOWN);
  assign running  = (r_run == RS_RUN);

  // Front-panel LED encodings
  always_comb begin
    led_mode     = (r_mode == MODE_DOWN) ? 2'b10 : 2'b01;
    led_run_stop = 2'b01;
    unique case (r_run)
      RS_RUN:   led_run_stop = 2'b10;
      RS_CLEAR: led_run_stop = 2'b00;
      default:  led_run_stop = 2'b01;
    endcase
  end

  a_step_legal: assert property (
    @(posedge clk) disable iff (reset) int'(step) <= MAX_COUNT
  );

endmodule

// File: tb/tb_prog_updown_counter.sv
// Randomised and directed bench for prog_updown_counter.
// Reference model works on plain integers advanced once per clock.
module tb_prog_updown_counter;

  localparam int DIV  = 10;
  localparam int MAXC = 9;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode;
  logic       btn_run_stop;
  logic       btn_clear;
  logic       load;
  logic [3:0] load_value;
  logic [3:0] step;
  logic       wrap_en;
  logic [3:0] count;
  logic       tc_pulse;
  logic       mode;
  logic       running;
  logic [1:0] led_mode;
  logic [1:0] led_run_stop;

  prog_updown_counter #(
    .CLK_HZ(10),
    .TICK_HZ(1),
    .MAX_COUNT(9),
    .STEP_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_mode(btn_mode),
    .btn_run_stop(btn_run_stop),
    .btn_clear(btn_clear),
    .load(load),
    .load_value(load_value),
    .step(step),
    .wrap_en(wrap_en),
    .count(count),
    .tc_pulse(tc_pulse),
    .mode(mode),
    .running(running),
    .led_mode(led_mode),
    .led_run_stop(led_run_stop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // model: st 0 = stopped, 1 = running, 2 = clearing
  int m_count;
  int m_tc;
  int m_mode;
  int m_st;
  int m_phase;

  task automatic model_reset();
    m_count = 0;
    m_tc    = 0;
    m_mode  = 0;
    m_st    = 0;
    m_phase = 0;
  endtask

  task automatic clk_cycle();
    int n_count, n_tc, n_mode, n_st, n_phase, s;
    bit tk, sat;
    tk = (m_st == 1) && (m_phase == DIV - 1);
    sat = 0;
    n_tc = 0;
    n_count = m_count;
    if (m_st == 2) n_count = 0;
    else if (load) n_count = (int'(load_value) > MAXC) ? MAXC : int'(load_value);
    else if (tk) begin
      if (m_mode == 0) begin
        s = m_count + int'(step);
        if (s <= MAXC) n_count = s;
        else begin
          n_tc = 1;
          if (wrap_en) n_count = s - (MAXC + 1);
          else begin n_count = MAXC; sat = 1; end
        end
      end else begin
        if (m_count >= int'(step)) n_count = m_count - int'(step);
        else begin
          n_tc = 1;
          if (wrap_en) n_count = m_count + MAXC + 1 - int'(step);
          else begin n_count = 0; sat = 1; end
        end
      end
    end
    n_mode = btn_mode ? 1 - m_mode : m_mode;
    n_st = m_st;
    if (m_st == 0) n_st = btn_run_stop ? 1 : (btn_clear ? 2 : 0);
    else if (m_st == 1) n_st = (btn_run_stop || sat) ? 0 : 1;
    else n_st = 0;
    n_phase = m_phase;
    if (m_st == 1) n_phase = (m_phase + 1) % DIV;
    else if (m_st == 2) n_phase = 0;
    @(posedge clk);
    m_count = n_count;
    m_tc    = n_tc;
    m_mode  = n_mode;
    m_st    = n_st;
    m_phase = n_phase;
    #1;
  endtask

  task automatic pulse_rs();
    btn_run_stop = 1'b1;
    clk_cycle();
    btn_run_stop = 1'b0;
  endtask

  task automatic pulse_clear();
    btn_clear = 1'b1;
    clk_cycle();
    btn_clear = 1'b0;
  endtask

  task automatic pulse_mode();
    btn_mode = 1'b1;
    clk_cycle();
    btn_mode = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    btn_mode = 0; btn_run_stop = 0; btn_clear = 0;
    load = 0; load_value = 0; step = 4'd1; wrap_en = 1'b1;
    model_reset();
    #12;
    checks++;
    if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++;
    if (tc_pulse !== 1'b0) begin failures++; $display("FAIL reset_tc got=%b exp=0", tc_pulse); end
    checks++;
    if (mode !== 1'b0) begin failures++; $display("FAIL reset_mode got=%b exp=0", mode); end
    checks++;
    if (running !== 1'b0) begin failures++; $display("FAIL reset_running got=%b exp=0", running); end
    checks++;
    if (led_mode !== 2'b01) begin failures++; $display("FAIL reset_led_mode got=%b exp=01", led_mode); end
    checks++;
    if (led_run_stop !== 2'b01) begin failures++; $display("FAIL reset_led_rs got=%b exp=01", led_run_stop); end
    reset = 1'b0;
  endtask

  task automatic test_count_up();
    step = 4'd1;
    wrap_en = 1'b1;
    pulse_rs();
    for (int i = 1; i <= 105; i++) begin
      clk_cycle();
      checks++;
      if (count !== 4'(m_count)) begin failures++; $display("FAIL up_count cyc=%0d got=%0d exp=%0d", i, count, m_count); end
      checks++;
      if (tc_pulse !== 1'(m_tc)) begin failures++; $display("FAIL up_tc cyc=%0d got=%b exp=%0d", i, tc_pulse, m_tc); end
      if (i == 9 || i == 10) begin
        checks++;
        if (count !== 4'(i / 10)) begin failures++; $display("FAIL up_first_tick cyc=%0d got=%0d exp=%0d", i, count, i / 10); end
      end
      if (i == 100) begin
        checks++;
        if (count !== 4'd0 || tc_pulse !== 1'b1) begin
          failures++; $display("FAIL up_wrap got=%0d/%b exp=0/1", count, tc_pulse);
        end
      end
      if (i == 101) begin
        checks++;
        if (tc_pulse !== 1'b0) begin failures++; $display("FAIL up_tc_width got=%b exp=0", tc_pulse); end
      end
    end
  endtask

  task automatic test_down_wrap();
    int exp;
    pulse_rs();
    pulse_clear();
    clk_cycle();
    load = 1'b1; load_value = 4'd1;
    clk_cycle();
    load = 1'b0;
    pulse_mode();
    step = 4'd3;
    pulse_rs();
    for (int i = 1; i <= 30; i++) begin
      clk_cycle();
      checks++;
      if (count !== 4'(m_count) || tc_pulse !== 1'(m_tc)) begin
        failures++; $display("FAIL down_model cyc=%0d got=%0d/%b exp=%0d/%0d", i, count, tc_pulse, m_count, m_tc);
      end
      if (i % 10 == 0) begin
        exp = (i == 10) ? 8 : ((i == 20) ? 5 : 2);
        checks++;
        if (count !== 4'(exp) || tc_pulse !== (i == 10)) begin
          failures++; $display("FAIL down_wrap cyc=%0d got=%0d/%b exp=%0d/%b", i, count, tc_pulse, exp, i == 10);
        end
      end
    end
  endtask

  task automatic test_saturate();
    pulse_rs();
    pulse_clear();
    clk_cycle();
    pulse_mode();
    wrap_en = 1'b0;
    step = 4'd4;
    load = 1'b1; load_value = 4'd8;
    clk_cycle();
    load = 1'b0;
    pulse_rs();
    for (int i = 1; i <= 40; i++) begin
      clk_cycle();
      checks++;
      if (count !== 4'(m_count) || tc_pulse !== 1'(m_tc) || running !== (m_st == 1)) begin
        failures++; $display("FAIL sat_model cyc=%0d got=%0d/%b/%b exp=%0d/%0d/%0d", i, count, tc_pulse, running, m_count, m_tc, m_st);
      end
      if (i == 10) begin
        checks++;
        if (count !== 4'd9 || tc_pulse !== 1'b1 || led_run_stop !== 2'b01) begin
          failures++; $display("FAIL sat_event got=%0d/%b/%b exp=9/1/01", count, tc_pulse, led_run_stop);
        end
      end
    end
    checks++;
    if (count !== 4'd9 || running !== 1'b0) begin
      failures++; $display("FAIL sat_hold got=%0d/%b exp=9/0", count, running);
    end
  endtask

  task automatic test_clear();
    load = 1'b1; load_value = 4'd6;
    clk_cycle();
    load = 1'b0;
    pulse_clear();
    checks++;
    if (led_run_stop !== 2'b00 || count !== 4'd6) begin
      failures++; $display("FAIL clear_state got=%b/%0d exp=00/6", led_run_stop, count);
    end
    clk_cycle();
    checks++;
    if (led_run_stop !== 2'b01 || count !== 4'd0) begin
      failures++; $display("FAIL clear_done got=%b/%0d exp=01/0", led_run_stop, count);
    end
    step = 4'd1;
    pulse_rs();
    for (int i = 0; i < 3; i++) clk_cycle();
    pulse_clear();
    checks++;
    if (running !== 1'b1 || led_run_stop !== 2'b10) begin
      failures++; $display("FAIL clear_in_run got=%b/%b exp=1/10", running, led_run_stop);
    end
    for (int i = 0; i < 15; i++) begin
      clk_cycle();
      checks++;
      if (count !== 4'(m_count) || running !== (m_st == 1)) begin
        failures++; $display("FAIL clear_run_model got=%0d/%b exp=%0d/%0d", count, running, m_count, m_st);
      end
    end
    checks++;
    if (count !== 4'd1) begin failures++; $display("FAIL clear_ignored got=%0d exp=1", count); end
  endtask

  task automatic test_load();
    int n;
    wrap_en = 1'b1;
    load = 1'b1; load_value = 4'd12;
    clk_cycle();
    load = 1'b0;
    checks++;
    if (count !== 4'd9 || tc_pulse !== 1'b0) begin
      failures++; $display("FAIL load_clamp got=%0d/%b exp=9/0", count, tc_pulse);
    end
    n = 0;
    while (!(m_st == 1 && m_phase == DIV - 1) && n < 20) begin
      clk_cycle();
      n++;
    end
    checks++;
    if (n >= 20) begin failures++; $display("FAIL load_wait_tick got=timeout exp=tick"); end
    load = 1'b1; load_value = 4'd3;
    clk_cycle();
    load = 1'b0;
    checks++;
    if (count !== 4'd3 || tc_pulse !== 1'b0) begin
      failures++; $display("FAIL load_vs_tick got=%0d/%b exp=3/0", count, tc_pulse);
    end
    pulse_rs();
    pulse_clear();
    load = 1'b1; load_value = 4'd5;
    clk_cycle();
    load = 1'b0;
    checks++;
    if (count !== 4'd0) begin failures++; $display("FAIL load_vs_clear got=%0d exp=0", count); end
    clk_cycle();
  endtask

  task automatic test_pause_resume();
    int n;
    logic [3:0] prev;
    step = 4'd1;
    wrap_en = 1'b1;
    pulse_rs();
    n = 0;
    while (m_phase != 5 && n < 20) begin
      clk_cycle();
      n++;
    end
    checks++;
    if (n >= 20) begin failures++; $display("FAIL pause_wait got=timeout exp=phase5"); end
    pulse_rs();
    for (int i = 0; i < 20; i++) begin
      clk_cycle();
      checks++;
      if (count !== 4'(m_count) || running !== 1'b0) begin
        failures++; $display("FAIL pause_hold got=%0d/%b exp=%0d/0", count, running, m_count);
      end
    end
    prev = count;
    pulse_rs();
    n = 0;
    while (count === prev && n < 20) begin
      clk_cycle();
      n++;
    end
    checks++;
    if (n != 4) begin failures++; $display("FAIL resume_phase got=%0d exp=4", n); end
    checks++;
    if (count !== 4'(m_count)) begin failures++; $display("FAIL resume_count got=%0d exp=%0d", count, m_count); end
    pulse_mode();
    for (int i = 0; i < 3; i++) clk_cycle();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (count !== 4'd0 || tc_pulse !== 1'b0 || mode !== 1'b0 || running !== 1'b0 ||
        led_mode !== 2'b01 || led_run_stop !== 2'b01) begin
      failures++;
      $display("FAIL async_reset got=%0d/%b/%b/%b/%b/%b exp=0/0/0/0/01/01",
               count, tc_pulse, mode, running, led_mode, led_run_stop);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_random();
    logic [1:0] e_lm, e_lr;
    for (int i = 0; i < 400; i++) begin
      btn_mode     = ($urandom % 16) == 0;
      btn_run_stop = ($urandom % 12) == 0;
      btn_clear    = ($urandom % 8) == 0;
      load         = ($urandom % 10) == 0;
      load_value   = 4'($urandom % 16);
      if ($urandom % 20 == 0) step = 4'($urandom_range(0, 9));
      if ($urandom % 30 == 0) wrap_en = 1'($urandom % 2);
      clk_cycle();
      e_lm = (m_mode == 1) ? 2'b10 : 2'b01;
      e_lr = (m_st == 1) ? 2'b10 : ((m_st == 2) ? 2'b00 : 2'b01);
      checks++;
      if (count !== 4'(m_count) || tc_pulse !== 1'(m_tc)) begin
        failures++; $display("FAIL rnd_count cyc=%0d got=%0d/%b exp=%0d/%0d", i, count, tc_pulse, m_count, m_tc);
      end
      checks++;
      if (mode !== 1'(m_mode) || led_mode !== e_lm) begin
        failures++; $display("FAIL rnd_mode cyc=%0d got=%b/%b exp=%0d/%b", i, mode, led_mode, m_mode, e_lm);
      end
      checks++;
      if (running !== (m_st == 1) || led_run_stop !== e_lr) begin
        failures++; $display("FAIL rnd_run cyc=%0d got=%b/%b exp=%0d/%b", i, running, led_run_stop, m_st, e_lr);
      end
    end
    btn_mode = 0; btn_run_stop = 0; btn_clear = 0; load = 0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_down_wrap();
    test_saturate();
    test_clear();
    test_load();
    test_pause_resume();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/prog_updown_counter.md
Name: prog_updown_counter

Overview:
Parametrised successor to the fixed 0..9999 / 10 Hz up/down counter used on the board front panel. Integrates the tick prescaler, the mode FSM, the run/stop/clear FSM and the count datapath, and generalises them:
- configurable modulus and tick rate
- programmable step size
- wrap or saturate overflow policy
- synchronous preset load
- terminal-count pulse

It sits between the debounced button block and the 7-segment/BCD display driver.

Parameters:
CLK_HZ, 100_000_000, input clock frequency in Hz.
TICK_HZ, 10, count update rate in Hz; DIV = CLK_HZ/TICK_HZ, DIV >= 2.
MAX_COUNT, 9999, highest count value; the count range is 0..MAX_COUNT.
STEP_W, 4, width of the step input.
CNT_W, $clog2(MAX_COUNT+1), count width (derived localparam, not overridable).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
btn_mode  in  1  toggle UP/DOWN (debounced, single-cycle pulse)
btn_run_stop  in  1  toggle STOP/RUN (debounced pulse)
btn_clear  in  1  request clear (debounced pulse)
load  in  1  synchronous preset strobe
load_value  in  CNT_W  preset value
step  in  STEP_W  increment/decrement amount per tick
wrap_en  in  1  1 = modular wrap, 0 = saturate and stop
count  out  CNT_W  current count, registered
tc_pulse  out  1  one-cycle pulse on wrap or saturation
mode  out  1  0 = UP, 1 = DOWN
running  out  1  high in RUN
led_mode  out  2  01 = UP, 10 = DOWN
led_run_stop  out  2  01 = STOP, 10 = RUN, 00 = CLEAR

Behaviour:
- Reset (async, any time including mid-count):
  - count = 0, tc_pulse = 0, prescaler = 0.
  - Mode FSM = UP (mode = 0, led_mode = 01).
  - Run FSM = STOP (running = 0, led_run_stop = 01).
- Mode FSM: UP <-> DOWN toggles on the edge after btn_mode. The new direction applies from the next tick.
- Run FSM states STOP, RUN, CLEAR:
  - STOP: btn_run_stop -> RUN; else btn_clear -> CLEAR (run_stop has priority).
  - RUN: btn_run_stop -> STOP. btn_clear is ignored. A saturation event -> STOP.
  - CLEAR: lasts exactly one cycle, then -> STOP unconditionally.
- Prescaler:
  - Counts 0..DIV-1 only in RUN.
  - Tick is a one-cycle internal pulse when the prescaler = DIV-1; the prescaler then returns to 0.
  - Holds its value in STOP (pause/resume keeps phase). Zeroed in CLEAR.
  - First tick occurs DIV cycles after entering RUN from a zeroed prescaler.
- Count update priority per cycle: CLEAR state > load > tick.
  - CLEAR: count <= 0.
  - load: count <= min(load_value, MAX_COUNT). Accepted in any state; no tc_pulse.
  - Tick, UP: compute s = count + step in CNT_W+1 bits.
    - If s <= MAX_COUNT: count <= s.
    - Else if wrap_en: count <= s - (MAX_COUNT+1), tc_pulse.
    - Else: count <= MAX_COUNT, tc_pulse, FSM -> STOP.
  - Tick, DOWN: if count >= step, count <= count - step.
    - Else if wrap_en: count <= count + (MAX_COUNT+1) - step, tc_pulse.
    - Else: count <= 0, tc_pulse, FSM -> STOP.
- Step rules:
  - step = 0: tick leaves count unchanged; no tc_pulse.
  - step > MAX_COUNT is illegal and must be guarded by an assertion.
- Output timing:
  - tc_pulse is registered, high in the cycle after the update edge, for one cycle only.
  - Saturation in the same cycle as btn_run_stop: FSM goes to STOP (both requests agree).

Optional Feature:
Macro BTN_EDGE_DET_EN.
- Defined: each button input passes through a registered rising-edge detector. A held button acts once, and every button response gains one cycle of latency.
- Undefined: buttons must be single-cycle pulses. A button held high toggles its FSM every cycle.

Test Plan:
Sim parameters: CLK_HZ = 10, TICK_HZ = 1 (DIV = 10), MAX_COUNT = 9, wrap_en = 1.
1. Reset, btn_run_stop, step = 1, UP -> count 1 after 10 cycles, +1 every 10 cycles; 9 -> 0 with tc_pulse high for 1 cycle.
2. DOWN, count = 1, step = 3 -> next tick count = 8, tc_pulse = 1; then 5, 2.
3. wrap_en = 0, UP, count = 8, step = 4 -> count = 9, tc_pulse, led_run_stop = 01, no further ticks.
4. STOP, count = 6, btn_clear -> one cycle led_run_stop = 00, then count = 0 and STOP. Same pulse in RUN -> ignored, count keeps running.
5. load = 1 with load_value = 12 -> count = 9. load coincident with a tick -> load value wins. Clear state with load -> count = 0.
6. RUN with prescaler = 5, btn_run_stop, wait 20 cycles, btn_run_stop -> next tick after 4 more cycles. Async reset mid-RUN -> all outputs at reset values immediately.
